fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Fetch stage plus IF/ID pipeline register of the pipelined RV32I core. It holds the PC and drives the instruction memory address. It latches the returned word into the Decode-side registers (InstrD, PCD, PCPlus4D) that feed the Decode stage, including its immediate extender. It also honours hazard-unit stall/flush, EX-stage redirects and instruction-memory wait states.

Parameters:
WIDTH, 32, datapath/address width (XLEN)
RESET_PC, 32'hBFC00000, PC value loaded on reset
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on flush/wait

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
StallF  in  1  hazard unit: hold PC
StallD  in  1  hazard unit: hold IF/ID register
FlushD  in  1  hazard unit: load bubble into IF/ID
PCSrcE  in  1  EX stage: taken branch/jump, redirect PC
PCTargetE  in  WIDTH  EX stage redirect target
ImemAddr  out  WIDTH  instruction memory address (= PCF, combinational)
ImemData  in  WIDTH  instruction word for ImemAddr, same-cycle read
ImemReady  in  1  ImemData valid this cycle; 0 = wait state
PCF  out  WIDTH  current fetch PC
InstrD  out  WIDTH  decode instruction
PCD  out  WIDTH  decode PC
PCPlus4D  out  WIDTH  decode PC+4
ValidD  out  1  InstrD is a real fetched instruction (0 = bubble)
FetchCount  out  32  perf counter (see optional feature)
FlushCount  out  32  perf counter (see optional feature)

Behaviour:
- Reset (rst_n low, async, no clock needed): PCF=RESET_PC; InstrD=NOP_INSTR; PCD=0; PCPlus4D=0; ValidD=0; counters=0. First fetch is RESET_PC in the first cycle after release.
- PCPlus4F = PCF+4, mod 2^WIDTH (0xFFFFFFFC -> 0x00000000).
- Redirect target = {PCTargetE[WIDTH-1:2],2'b00}. Low bits are silently cleared.
- PC register next-state, in priority order:
  1. PCSrcE=1 -> target. Overrides StallF and ImemReady.
  2. StallF=1 -> hold.
  3. ImemReady=0 -> hold.
  4. Otherwise -> PCPlus4F.
- IF/ID register next-state, in priority order:
  1. FlushD=1 or PCSrcE=1 -> bubble: InstrD=NOP_INSTR, ValidD=0. PCD/PCPlus4D hold. Flush wins over StallD.
  2. StallD=1 -> hold all four outputs.
  3. ImemReady=0 -> bubble.
  4. Otherwise -> InstrD=ImemData, PCD=PCF, PCPlus4D=PCPlus4F, ValidD=1.
- Latency: instruction at PCF appears on InstrD one cycle after a cycle where ImemReady=1 and no stall/flush.
- StallF=1 with StallD=0 is legal and produces duplicate-free bubbles only via FlushD. Hazard unit asserts both together for load-use; the block does not check this.
- Redirect during an imem wait: the waited-on fetch is abandoned and the next cycle fetches the target.
- No state machine beyond the registers. Wait states are absorbed by PC hold.

Optional Feature:
FETCH_PERF_EN defined:
- FetchCount increments on every IF/ID load with ValidD'=1.
- FlushCount increments on every cycle where FlushD|PCSrcE is 1.
- Both counters wrap at 2^32 and are reset by rst_n.

FETCH_PERF_EN undefined:
- FetchCount and FlushCount are tied to 0.
- No counter flops are synthesised.

Decomposition:
- Shared package core_pkg: XLEN, RESET_PC, NOP_INSTR constants.
- Sub-module if_id_reg: enable/flush register holding InstrD/PCD/PCPlus4D/ValidD.
- fetch_stage owns the PC register, next-PC logic and the counters.

Test Plan:
- Reset release, ImemReady=1, no hazards -> PCF 0xBFC00000, 0xBFC00004, 0xBFC00008. InstrD follows ImemData one cycle later with ValidD=1 from cycle 2.
- StallF=StallD=1 for 2 cycles at PCF=0xBFC00008 -> PCF and all D outputs frozen. Sequence resumes at 0xBFC0000C with no lost or duplicated instruction.
- PCSrcE=1, PCTargetE=0xBFC00103 with StallD=1 -> next PCF=0xBFC00100. InstrD=0x00000013, ValidD=0. Target instruction is in D two cycles later.
- ImemReady=0 for 3 cycles -> PCF held. Three bubbles (ValidD=0) enter D. The held-PC instruction is delivered when ImemReady=1.
- rst_n pulsed low mid-stream, asynchronously and between clock edges -> outputs take reset values immediately. Fetch restarts at RESET_PC.
- With FETCH_PERF_EN: 10 clean fetches + 1 redirect -> FetchCount=10, FlushCount=1. Without FETCH_PERF_EN: both read 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core constants: datapath width, reset vector and bubble encoding.
package core_pkg;
   localparam int          XLEN      = 32;
   localparam logic [31:0] RESET_PC  = 32'hBFC00000;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush (bubble) beats stall; imem wait inserts a bubble.
// One-cycle latency from fetch to decode; stall holds all four outputs.
module if_id_reg
#(
   parameter int               WIDTH     = core_pkg::XLEN,
   parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(core_pkg::NOP_INSTR)
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             stall,
   input  logic             fetch_rdy,
   input  logic [WIDTH-1:0] instr_in,
   input  logic [WIDTH-1:0] pc_in,
   input  logic [WIDTH-1:0] pc_plus4_in,
   output logic [WIDTH-1:0] instr_out,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus4_out,
   output logic             valid_out
);
   import core_pkg::*;

   logic [WIDTH-1:0] instr_q, instr_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pc_plus4_q, pc_plus4_d;
   logic             valid_q, valid_d;

   // Bubbles keep PCD/PCPlus4D so decode still sees the last real PC.
   always_comb begin
      instr_d    = instr_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      if (flush) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (!stall) begin
         if (fetch_rdy) begin
            instr_d    = instr_in;
            pc_d       = pc_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = 1'b1;
         end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q    <= NOP_INSTR;
         pc_q       <= '0;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   assign instr_out    = instr_q;
   assign pc_out       = pc_q;
   assign pc_plus4_out = pc_plus4_q;
   assign valid_out    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC register, next-PC priority (redirect > stall > imem wait), IF/ID register.
// Optional perf counters FetchCount/FlushCount exist only when FETCH_PERF_EN is defined.
module fetch_stage
#(
   parameter int               WIDTH     = core_pkg::XLEN,
   parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(core_pkg::RESET_PC),
   parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(core_pkg::NOP_INSTR)
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             FlushD,
   input  logic             PCSrcE,
   input  logic [WIDTH-1:0] PCTargetE,
   output logic [WIDTH-1:0] ImemAddr,
   input  logic [WIDTH-1:0] ImemData,
   input  logic             ImemReady,
   output logic [WIDTH-1:0] PCF,
   output logic [WIDTH-1:0] InstrD,
   output logic [WIDTH-1:0] PCD,
   output logic [WIDTH-1:0] PCPlus4D,
   output logic             ValidD,
   output logic [31:0]      FetchCount,
   output logic [31:0]      FlushCount
);
   import core_pkg::*;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pc_plus4_f;
   logic [WIDTH-1:0] redirect_target;
   logic             bubble_d;

   // A redirect abandons any waited-on fetch, so it ignores StallF and ImemReady.
   always_comb begin
      pc_plus4_f      = pc_q + WIDTH'(4);
      redirect_target = PCTargetE & ~WIDTH'(3);
      bubble_d        = FlushD | PCSrcE;
      pc_d            = pc_q;
      if (PCSrcE) begin
         pc_d = redirect_target;
      end else if (!StallF && ImemReady) begin
         pc_d = pc_plus4_f;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign PCF      = pc_q;
   assign ImemAddr = pc_q;

   if_id_reg #(
      .WIDTH     (WIDTH),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (bubble_d),
      .stall        (StallD),
      .fetch_rdy    (ImemReady),
      .instr_in     (ImemData),
      .pc_in        (pc_q),
      .pc_plus4_in  (pc_plus4_f),
      .instr_out    (InstrD),
      .pc_out       (PCD),
      .pc_plus4_out (PCPlus4D),
      .valid_out    (ValidD)
   );

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;
   logic        fetch_load;

   always_comb begin
      fetch_load  = !bubble_d && !StallD && ImemReady;
      fetch_cnt_d = fetch_cnt_q + 32'(fetch_load);
      flush_cnt_d = flush_cnt_q + 32'(bubble_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign FetchCount = fetch_cnt_q;
   assign FlushCount = flush_cnt_q;
`else
   assign FetchCount = '0;
   assign FlushCount = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: driver pushes predicted post-edge state, negedge monitor compares.
module tb_fetch_stage;
   localparam logic [31:0] RST_PC = 32'hBFC00000;
   localparam logic [31:0] NOP    = 32'h00000013;

   logic        clk;
   logic        rst_n;
   logic        StallF, StallD, FlushD, PCSrcE, ImemReady;
   logic [31:0] PCTargetE, ImemAddr, ImemData, PCF, InstrD, PCD, PCPlus4D;
   logic        ValidD;
   logic [31:0] FetchCount, FlushCount;

   typedef struct {
      logic [31:0] pcf;
      logic [31:0] instr;
      logic [31:0] pcd;
      logic [31:0] pcp4;
      logic        valid;
      logic [31:0] fc;
      logic [31:0] flc;
   } exp_t;

   exp_t model;
   exp_t mon_e;
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 0;

   fetch_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .StallF     (StallF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .ImemAddr   (ImemAddr),
      .ImemData   (ImemData),
      .ImemReady  (ImemReady),
      .PCF        (PCF),
      .InstrD     (InstrD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD),
      .FetchCount (FetchCount),
      .FlushCount (FlushCount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a * 32'h9E3779B1 + 32'h00001001;
   endfunction

   assign ImemData = mem_word(ImemAddr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t reset_state();
      exp_t s;
      s.pcf   = RST_PC;
      s.instr = NOP;
      s.pcd   = 32'h0;
      s.pcp4  = 32'h0;
      s.valid = 1'b0;
      s.fc    = 32'h0;
      s.flc   = 32'h0;
      return s;
   endfunction

   // Reference: what the fetch/decode state should be after one clock with these controls.
   function automatic exp_t next_state(input exp_t s, input bit sf, input bit sd, input bit fd,
                                       input bit ps, input logic [31:0] tgt, input bit rdy);
      exp_t n = s;
      bit   killed = fd || ps;
      if (ps)              n.pcf = {tgt[31:2], 2'b00};
      else if (!sf && rdy) n.pcf = s.pcf + 32'd4;
      if (killed || (!sd && !rdy)) begin
         n.instr = NOP;
         n.valid = 1'b0;
      end else if (!sd) begin
         n.instr = mem_word(s.pcf);
         n.pcd   = s.pcf;
         n.pcp4  = s.pcf + 32'd4;
         n.valid = 1'b1;
`ifdef FETCH_PERF_EN
         n.fc    = s.fc + 32'd1;
`endif
      end
`ifdef FETCH_PERF_EN
      if (killed) n.flc = s.flc + 32'd1;
`endif
      return n;
   endfunction

   task automatic step(input bit sf, input bit sd, input bit fd, input bit ps,
                       input logic [31:0] tgt, input bit rdy);
      StallF    = sf;
      StallD    = sd;
      FlushD    = fd;
      PCSrcE    = ps;
      PCTargetE = tgt;
      ImemReady = rdy;
      model = next_state(model, sf, sd, fd, ps, tgt, rdy);
      exp_q.push_back(model);
      @(posedge clk);
      #1;
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 1);
   endtask

   // Reset asserted between clock edges; outputs must reset without any clock edge.
   task automatic async_reset();
      mon_en = 0;
      exp_q.delete();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_pcf",      PCF,             RST_PC);
      check("rst_instr",    InstrD,          NOP);
      check("rst_pcd",      PCD,             32'h0);
      check("rst_pcp4",     PCPlus4D,        32'h0);
      check("rst_valid",    32'(ValidD),     32'h0);
      check("rst_fetchcnt", FetchCount,      32'h0);
      check("rst_flushcnt", FlushCount,      32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model = reset_state();
      exp_q.push_back(model);
      mon_en = 1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no expectation, required one at %0t", $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("PCF",        PCF,         mon_e.pcf);
            check("ImemAddr",   ImemAddr,    mon_e.pcf);
            check("InstrD",     InstrD,      mon_e.instr);
            check("PCD",        PCD,         mon_e.pcd);
            check("PCPlus4D",   PCPlus4D,    mon_e.pcp4);
            check("ValidD",     32'(ValidD), 32'(mon_e.valid));
            check("FetchCount", FetchCount,  mon_e.fc);
            check("FlushCount", FlushCount,  mon_e.flc);
         end
      end
   end

   initial begin
      rst_n     = 1'b1;
      StallF    = 0;
      StallD    = 0;
      FlushD    = 0;
      PCSrcE    = 0;
      PCTargetE = 32'h0;
      ImemReady = 1;
      #1;
      async_reset();

      // Clean fetch from the reset vector.
      clean(2);
      check("seq_pcf", PCF, 32'hBFC00008);
      check("seq_pcd", PCD, 32'hBFC00004);

      // Load-use style freeze of F and D.
      step(1, 1, 0, 0, 32'h0, 1);
      step(1, 1, 0, 0, 32'h0, 1);
      check("stall_pcf", PCF, 32'hBFC00008);
      check("stall_pcd", PCD, 32'hBFC00004);
      clean(1);
      check("resume_pcd", PCD, 32'hBFC00008);

      // Redirect overrides StallD; unaligned target low bits dropped.
      step(0, 1, 0, 1, 32'hBFC00103, 1);
      check("redir_pcf",   PCF,         32'hBFC00100);
      check("redir_instr", InstrD,      NOP);
      check("redir_valid", 32'(ValidD), 32'h0);
      clean(1);
      check("target_pcd", PCD, 32'hBFC00100);

      // Three imem wait states.
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h0, 0);
      check("wait_pcf",   PCF,         32'hBFC00104);
      check("wait_valid", 32'(ValidD), 32'h0);
      clean(1);
      check("wait_done_pcd", PCD, 32'hBFC00104);

      // Randomised hazards, redirects and wait states.
      for (int i = 0; i < 400; i++) begin
         bit sf, sd, fd, ps, rdy;
         int r;
         r   = int'($urandom_range(0, 99));
         sf  = (r < 12);
         sd  = (r < 10) || ($urandom_range(0, 99) < 4);
         fd  = ($urandom_range(0, 99) < 8);
         ps  = ($urandom_range(0, 99) < 7);
         rdy = ($urandom_range(0, 99) < 80);
         step(sf, sd, fd, ps, $urandom, rdy);
      end
      // Wrap of PC+4 at the top of the address space.
      step(0, 0, 0, 1, 32'hFFFFFFFE, 1);
      clean(2);

      // Mid-stream async reset, then perf-counter scenario.
      async_reset();
      clean(10);
      step(0, 0, 0, 1, 32'h00000040, 1);
`ifdef FETCH_PERF_EN
      check("perf_fetch", FetchCount, 32'd10);
      check("perf_flush", FlushCount, 32'd1);
`else
      check("perf_fetch_off", FetchCount, 32'd0);
      check("perf_flush_off", FlushCount, 32'd0);
`endif
      clean(2);

      @(negedge clk);
      #1;
      mon_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
